// File: rtl/spc700_seq_ctrl_pkg.sv
// Shared definitions for the SPC700 instruction-cycle sequencer.
//
// Contents:
//   SEQ_*        2-bit stateCtrl encodings carried by each microinstruction
//   OP_*         opcodes that get special sequencing
//                (MUL/DIV extension loops, SLEEP/STOP halt)
//   SpcSeqSt_e   top-level sequencer phase
//   helpers      opcode classification used by the sequencer decode
package spc700_seq_ctrl_pkg;

  localparam logic [1:0] SEQ_NEXT = 2'b00;
  localparam logic [1:0] SEQ_END  = 2'b01;
  localparam logic [1:0] SEQ_COND = 2'b10;
  localparam logic [1:0] SEQ_LOOP = 2'b11;

  localparam logic [7:0] OP_MUL   = 8'hCF;
  localparam logic [7:0] OP_DIV   = 8'h9E;
  localparam logic [7:0] OP_SLEEP = 8'hEF;
  localparam logic [7:0] OP_STOP  = 8'hFF;

  typedef enum logic [1:0] {
    SEQ_FETCH,
    SEQ_EXEC,
    SEQ_EXT,
    SEQ_HALT
  } SpcSeqSt_e;

  // SLEEP and STOP both freeze the core once their final cycle completes.
  function automatic logic is_halt_op(input logic [7:0] op);
    return (op == OP_SLEEP) || (op == OP_STOP);
  endfunction

  // Only MUL and DIV own microcode extension rows; LOOP elsewhere degrades to NEXT.
  function automatic logic is_loop_op(input logic [7:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/spc700_seq_ctrl.sv
// SPC700 instruction-cycle sequencer.
//
// Owns the instruction register and the 4-bit microcode step that together
// address the microcode ROM ({ir, state[2:0]}, state[3] selects the MUL/DIV
// extension rows). Each enabled cycle it either fetches an opcode or decodes
// the current microinstruction's stateCtrl field (advance, end, conditional,
// loop). MUL/DIV iteration cycles are counted here, and SLEEP/STOP latch a
// halt that only reset clears.
//
// Ports:
//   clk          core clock
//   rst          asynchronous active-high reset
//   en           bus-cycle enable; every register holds while low
//   state_ctrl   stateCtrl of the current microinstruction
//   branch_taken condition result, used only for COND
//   dbus_in      data bus; opcode byte on fetch cycles
//   ir           instruction register
//   state        microcode step
//   ir_load      current cycle is an opcode fetch
//   loop_cnt     extension-cycle index, 0 outside loops
//   halted       SLEEP/STOP executed, core frozen
//   seq_err      sticky flag: advance requested at step 7
module spc700_seq_ctrl #(
  parameter int MUL_LOOP = 6,
  parameter int DIV_LOOP = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] state_ctrl,
  input  logic       branch_taken,
  input  logic [7:0] dbus_in,
  output logic [7:0] ir,
  output logic [3:0] state,
  output logic       ir_load,
  output logic [3:0] loop_cnt,
  output logic       halted,
  output logic       seq_err
);

  import spc700_seq_ctrl_pkg::*;

  localparam logic [3:0] MUL_LAST = 4'(MUL_LOOP - 1);
  localparam logic [3:0] DIV_LAST = 4'(DIV_LOOP - 1);

  SpcSeqSt_e  seq_st, seq_st_n;
  logic [7:0] ir_n;
  logic [3:0] state_n;
  logic [3:0] loop_cnt_n;
  logic [2:0] ret, ret_n;
  logic       seq_err_n;

  logic [1:0] ctrl_eff;
  logic [3:0] loop_last;
  logic [3:0] cnt_inc;

  // Fetch and halt are phases of the sequencer rather than separate flops,
  // so they can never disagree with the phase register.
  assign ir_load = (seq_st == SEQ_FETCH);
  assign halted  = (seq_st == SEQ_HALT);

  assign loop_last = (ir == OP_DIV) ? DIV_LAST : MUL_LAST;
  assign cnt_inc   = loop_cnt + 4'd1;

  // Reduce COND and illegal LOOP to the plain action they stand for, so the
  // execute decode below only has to handle NEXT, END and a genuine LOOP.
  always_comb begin
    ctrl_eff = state_ctrl;
    if (state_ctrl == SEQ_COND) begin
      ctrl_eff = branch_taken ? SEQ_NEXT : SEQ_END;
    end else if (state_ctrl == SEQ_LOOP && !is_loop_op(ir)) begin
      ctrl_eff = SEQ_NEXT;
    end
  end

  // Next-state logic. Everything holds by default; halt holds forever.
  // Inside an extension loop stateCtrl is ignored and only the counter runs.
  always_comb begin
    seq_st_n   = seq_st;
    ir_n       = ir;
    state_n    = state;
    loop_cnt_n = loop_cnt;
    ret_n      = ret;
    seq_err_n  = seq_err;

    case (seq_st)
      SEQ_FETCH: begin
        ir_n     = dbus_in;
        state_n  = 4'd1;
        seq_st_n = SEQ_EXEC;
      end

      SEQ_EXT: begin
        if (loop_cnt == loop_last) begin
          state_n    = {1'b0, ret};
          loop_cnt_n = 4'd0;
          seq_st_n   = SEQ_EXEC;
        end else begin
          loop_cnt_n = cnt_inc;
          // DIV walks extension rows 8..B; MUL sits on row 8.
          if (ir == OP_DIV) begin
            state_n = {2'b10, cnt_inc[1:0]};
          end
        end
      end

      SEQ_EXEC: begin
        case (ctrl_eff)
          SEQ_END: begin
            state_n  = 4'd0;
            seq_st_n = is_halt_op(ir) ? SEQ_HALT : SEQ_FETCH;
          end
          SEQ_LOOP: begin
            ret_n      = state[2:0] + 3'd1;
            state_n    = 4'b1000;
            loop_cnt_n = 4'd0;
            seq_st_n   = SEQ_EXT;
          end
          default: begin
            // Step 7 is the last row of an instruction; advancing past it
            // would alias into the next opcode's rows, so hold and flag.
            if (state[2:0] == 3'd7) begin
              seq_err_n = 1'b1;
            end else begin
              state_n = state + 4'd1;
            end
          end
        endcase
      end

      default: begin
      end
    endcase
  end

  // State register; en low freezes the whole sequencer including the loop count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_st   <= SEQ_FETCH;
      ir       <= 8'h00;
      state    <= 4'd0;
      loop_cnt <= 4'd0;
      ret      <= 3'd0;
      seq_err  <= 1'b0;
    end else if (en) begin
      seq_st   <= seq_st_n;
      ir       <= ir_n;
      state    <= state_n;
      loop_cnt <= loop_cnt_n;
      ret      <= ret_n;
      seq_err  <= seq_err_n;
    end
  end

endmodule

// File: tb/tb_spc700_seq_ctrl.sv
// Scoreboard testbench for spc700_seq_ctrl.
//
// The stimulus process drives one cycle of inputs just after each rising
// edge and pushes the outputs the sequencer must present during that cycle.
// The monitor pops one entry at every falling edge and compares it against
// the DUT outputs.
module tb_spc700_seq_ctrl;

  localparam logic [1:0] NXT = 2'b00;
  localparam logic [1:0] ENDC = 2'b01;
  localparam logic [1:0] CND = 2'b10;
  localparam logic [1:0] LOP = 2'b11;

  typedef struct packed {
    logic [7:0] ir;
    logic [3:0] st;
    logic       ld;
    logic [3:0] cnt;
    logic       halt;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] state_ctrl;
  logic       branch_taken;
  logic [7:0] dbus_in;
  logic [7:0] ir;
  logic [3:0] state;
  logic       ir_load;
  logic [3:0] loop_cnt;
  logic       halted;
  logic       seq_err;

  exp_t expQ[$];
  exp_t popped;
  int   nVec = 0;
  int   nMis = 0;

  spc700_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .state_ctrl   (state_ctrl),
    .branch_taken (branch_taken),
    .dbus_in      (dbus_in),
    .ir           (ir),
    .state        (state),
    .ir_load      (ir_load),
    .loop_cnt     (loop_cnt),
    .halted       (halted),
    .seq_err      (seq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [7:0] xir, input logic [3:0] xst, input logic xld,
                              input logic [3:0] xcnt, input logic xh, input logic xerr);
    exp_t e;
    e.ir = xir; e.st = xst; e.ld = xld; e.cnt = xcnt; e.halt = xh; e.err = xerr;
    return e;
  endfunction

  // Compare one expected record against what the DUT currently presents.
  task automatic checkOutput(input exp_t e);
    exp_t act;
    act = mk(ir, state, ir_load, loop_cnt, halted, seq_err);
    nVec++;
    if (act !== e) begin
      nMis++;
      $display("[TB] FAIL vec%0d: got ir=%h st=%h ld=%b cnt=%0d halt=%b err=%b, expected ir=%h st=%h ld=%b cnt=%0d halt=%b err=%b",
               nVec, act.ir, act.st, act.ld, act.cnt, act.halt, act.err,
               e.ir, e.st, e.ld, e.cnt, e.halt, e.err);
    end
  endtask

  // Monitor: each cycle the DUT presents a new set of outputs.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      popped = expQ.pop_front();
      checkOutput(popped);
    end
  end

  // One cycle: drive inputs, record what must be visible this cycle, advance.
  task automatic applyStimulus(input logic e, input logic [1:0] c, input logic b,
                               input logic [7:0] d, input exp_t x);
    en = e; state_ctrl = c; branch_taken = b; dbus_in = d;
    expQ.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    en = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // MUL run: fetch CF, NEXT x3, LOOP at step 4, six extension cycles, back to
  // step 5, END at step 6. With stretch set, each cycle is preceded by an
  // en-low cycle carrying junk inputs that must change nothing.
  task automatic runMul(input logic [7:0] prevIr, input logic stretch);
    logic [1:0] c;
    logic [3:0] st;
    logic [3:0] cnt;
    logic [7:0] xir;
    for (int k = 0; k < 13; k++) begin
      cnt = 4'd0;
      xir = (k == 0) ? prevIr : 8'hCF;
      if (k == 0) begin
        c = LOP; st = 4'd0;
      end else if (k < 4) begin
        c = NXT; st = 4'(k);
      end else if (k == 4) begin
        c = LOP; st = 4'd4;
      end else if (k < 11) begin
        c = ENDC; st = 4'd8; cnt = 4'(k - 5);
      end else if (k == 11) begin
        c = NXT; st = 4'd5;
      end else begin
        c = ENDC; st = 4'd6;
      end
      if (stretch) begin
        applyStimulus(1'b0, ENDC, 1'b0, 8'hFF, mk(xir, st, (k == 0), cnt, 1'b0, 1'b0));
      end
      applyStimulus(1'b1, c, 1'b1, 8'hCF, mk(xir, st, (k == 0), cnt, 1'b0, 1'b0));
    end
  endtask

  initial begin
    en = 1'b0; rst = 1'b0; state_ctrl = NXT; branch_taken = 1'b0; dbus_in = 8'h00;
    doReset();

    // Simple three-cycle instruction E8.
    applyStimulus(1'b1, NXT,  1'b0, 8'hE8, mk(8'h00, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, NXT,  1'b0, 8'h00, mk(8'hE8, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, NXT,  1'b0, 8'h00, mk(8'hE8, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, ENDC, 1'b0, 8'h00, mk(8'hE8, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0));

    // Branch taken at step 2.
    applyStimulus(1'b1, NXT,  1'b0, 8'hD0, mk(8'hE8, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, NXT,  1'b0, 8'h00, mk(8'hD0, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, CND,  1'b1, 8'h00, mk(8'hD0, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, ENDC, 1'b0, 8'h00, mk(8'hD0, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0));
    // Branch not taken at step 2; LOOP on a non-MUL/DIV opcode acts as NEXT.
    applyStimulus(1'b1, ENDC, 1'b0, 8'hD0, mk(8'hD0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, LOP,  1'b0, 8'h00, mk(8'hD0, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, CND,  1'b0, 8'h00, mk(8'hD0, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0));

    // MUL loop, then the same run with en toggling.
    runMul(8'hD0, 1'b0);
    runMul(8'hCF, 1'b1);

    // DIV loop at step 3: rows 8,9,A,B,8,9,A,B,8 then step 4.
    applyStimulus(1'b1, NXT, 1'b0, 8'h9E, mk(8'hCF, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, NXT, 1'b0, 8'h00, mk(8'h9E, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, NXT, 1'b0, 8'h00, mk(8'h9E, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, LOP, 1'b0, 8'h00, mk(8'h9E, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, NXT, 1'b0, 8'h00,
                    mk(8'h9E, 4'(8 + (i % 4)), 1'b0, 4'(i), 1'b0, 1'b0));
    end
    applyStimulus(1'b1, ENDC, 1'b0, 8'h00, mk(8'h9E, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0));

    // Advance past step 7: hold at 7 and set sticky error.
    applyStimulus(1'b1, NXT, 1'b0, 8'h20, mk(8'h9E, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b1, NXT, 1'b0, 8'h00, mk(8'h20, 4'(i), 1'b0, 4'd0, 1'b0, 1'b0));
    end
    applyStimulus(1'b1, CND,  1'b1, 8'h00, mk(8'h20, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1));
    applyStimulus(1'b1, ENDC, 1'b0, 8'h00, mk(8'h20, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1));

    // STOP: halt, then nothing moves until reset.
    applyStimulus(1'b1, NXT,  1'b0, 8'hFF, mk(8'h20, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1));
    applyStimulus(1'b1, ENDC, 1'b0, 8'h00, mk(8'hFF, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 2'(i), i[0], 8'(8'h11 * i),
                    mk(8'hFF, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1));
    end
    doReset();
    applyStimulus(1'b0, NXT, 1'b0, 8'h00, mk(8'h00, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0));

    // Reset in the middle of a MUL loop.
    applyStimulus(1'b1, NXT,  1'b0, 8'hCF, mk(8'h00, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, LOP,  1'b0, 8'h00, mk(8'hCF, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, ENDC, 1'b0, 8'h00, mk(8'hCF, 4'd8, 1'b0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1'b1, ENDC, 1'b0, 8'h00, mk(8'hCF, 4'd8, 1'b0, 4'd1, 1'b0, 1'b0));
    doReset();
    applyStimulus(1'b0, NXT, 1'b0, 8'h00, mk(8'h00, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0));

    // Let the monitor drain.
    repeat (2) @(posedge clk);
    if (expQ.size() != 0) begin
      nVec++;
      nMis++;
      $display("[TB] FAIL drain: %0d expected entries left unchecked, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
